// File: rtl/int2flt_pkg.sv
// Shared types and constants for the integer-to-binary16 converter.
package int2flt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned EXP_BIAS  = 15;
  localparam int unsigned EXP_START = 30;
  localparam int unsigned MANT_W    = 10;
  localparam int unsigned WORD_W    = 16;
  localparam int unsigned EXP_W     = 5;

endpackage

// File: rtl/int2flt_unit_if.sv
// Start/halt handshake plus operand and result words of the converter.
interface int2flt_unit_if;
  import int2flt_pkg::*;

  logic              start;
  logic [WORD_W-1:0] int_in;
  logic [WORD_W-1:0] flt_out;
  logic              halt;

  modport master (output start, output int_in, input flt_out, input halt);
  modport slave  (input start, input int_in, output flt_out, output halt);

endinterface

// File: rtl/int2flt_unit_fp16_round.sv
// Combinational round-to-nearest-even packer for a normalized magnitude.
module fp16_round
  import int2flt_pkg::*;
(
  input  logic [WORD_W-1:0] mag,
  input  logic [EXP_W-1:0]  exp,
  input  logic              sign,
  input  logic              zero,
  output logic [WORD_W-1:0] word
);

  logic [MANT_W-1:0] mant;
  logic [MANT_W-1:0] mant_r;
  logic [MANT_W:0]   sum;
  logic [EXP_W-1:0]  exp_r;
  logic              guard;
  logic              sticky;
  logic              round_up;

  always_comb begin
    mant     = mag[14:5];
    guard    = mag[4];
    sticky   = |mag[3:0];
    round_up = guard & (sticky | mant[0]);
    sum      = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
    // mantissa carry-out renormalizes by bumping the exponent
    if (sum[MANT_W]) begin
      exp_r  = exp + 5'd1;
      mant_r = '0;
    end else begin
      exp_r  = exp;
      mant_r = sum[MANT_W-1:0];
    end
    if (zero || !mag[WORD_W-1]) begin
      word = '0;
    end else begin
      word = {sign, exp_r, mant_r};
    end
  end

endmodule

// File: rtl/int2flt_unit.sv
// Sequential int16 -> binary16 converter: one normalization shift per cycle, then round.
module int2flt_unit
  import int2flt_pkg::*;
(
  input  logic          CLK,
  input  logic          reset,
  int2flt_unit_if.slave bus
);

  state_t            state, state_nx;
  logic [WORD_W-1:0] mag;
  logic [EXP_W-1:0]  exp;
  logic              sign;
  logic              zero;
  logic [WORD_W-1:0] flt_q;
  logic [WORD_W-1:0] flt_rounded;

  logic accept;
  logic shift;
  logic set_zero;
  logic load_out;

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    shift    = 1'b0;
    set_zero = 1'b0;
    load_out = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = NORM;
        end
      end
      NORM: begin
        if (mag == '0) begin
          set_zero = 1'b1;
          state_nx = ROUND;
        end else if (mag[WORD_W-1]) begin
          state_nx = ROUND;
        end else begin
          shift = 1'b1;
        end
      end
      ROUND: begin
        load_out = 1'b1;
        state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= IDLE;
      mag   <= '0;
      exp   <= '0;
      sign  <= 1'b0;
      zero  <= 1'b0;
      flt_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sign <= bus.int_in[WORD_W-1];
        // -32768 negates to itself, which is the correct unsigned magnitude 0x8000
        mag  <= bus.int_in[WORD_W-1] ? (~bus.int_in + 16'd1) : bus.int_in;
        exp  <= EXP_W'(EXP_START);
        zero <= 1'b0;
      end
      if (shift) begin
        mag <= {mag[WORD_W-2:0], 1'b0};
        exp <= exp - 5'd1;
      end
      if (set_zero) begin
        zero <= 1'b1;
      end
      if (load_out) begin
        flt_q <= flt_rounded;
      end
    end
  end

  fp16_round u_round (
    .mag  (mag),
    .exp  (exp),
    .sign (sign),
    .zero (zero),
    .word (flt_rounded)
  );

  assign bus.flt_out = flt_q;
  assign bus.halt    = (state == DONE);

endmodule

// File: tb/tb_int2flt_unit.sv
// Self-checking bench for int2flt_unit: directed vectors, reset/restart sequences, random sweep.
module tb_int2flt_unit;
  import int2flt_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int2flt_unit_if bus ();

  int2flt_unit dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] din;
    logic [15:0] flt;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Wait for halt after an accepted start; n counts edges since E0.
  task automatic wait_done(input int first_n, input logic [15:0] prev,
                           output logic [15:0] res, output int lat);
    logic hold_ok;
    hold_ok = 1'b1;
    lat = -1;
    for (int n = first_n; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.halt) begin
        lat = n;
        break;
      end
      if (bus.flt_out !== prev) hold_ok = 1'b0;
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=no_halt required=halt_within_40");
    end
    check("flt_hold_while_busy", {31'd0, hold_ok}, 32'd1);
    res = bus.flt_out;
  endtask

  // Called at #1 after an edge; the next edge is E0.
  task automatic convert(input logic [15:0] din, output logic [15:0] res, output int lat);
    logic [15:0] prev;
    prev       = bus.flt_out;
    bus.int_in = din;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.int_in = 16'h5A5A;
    check("halt_drop_after_e0", {31'd0, bus.halt}, 32'd0);
    wait_done(1, prev, res, lat);
  endtask

  task automatic model(input logic [15:0] din, output logic [15:0] f, output int lat);
    real v, pw, scaled, frac;
    int  e, q, iv, lz;
    iv = int'($signed(din));
    v  = (iv < 0) ? real'(-iv) : real'(iv);
    if (iv == 0) begin
      f   = 16'h0000;
      lat = 2;
    end else begin
      e  = 0;
      pw = 1.0;
      while (pw * 2.0 <= v) begin
        pw = pw * 2.0;
        e++;
      end
      lz     = 15 - e;
      scaled = v / pw * 1024.0;
      q      = $rtoi(scaled);
      frac   = scaled - real'(q);
      if (frac > 0.5 || (frac == 0.5 && (q % 2) == 1)) q++;
      if (q == 2048) begin
        q = 1024;
        e++;
      end
      f   = {din[15], 5'(e + 15), 10'(q - 1024)};
      lat = lz + 2;
    end
  endtask

  initial begin
    logic [15:0] res, exp_f;
    int          lat, exp_lat;
    logic        halt_ok;

    vecs[0]  = '{16'h0000, 16'h0000, 2};
    vecs[1]  = '{16'h0001, 16'h3C00, 17};
    vecs[2]  = '{16'hFFFF, 16'hBC00, 17};
    vecs[3]  = '{16'h7FFF, 16'h7800, 3};
    vecs[4]  = '{16'h8000, 16'hF800, 2};
    vecs[5]  = '{16'h0801, 16'h6800, 6};
    vecs[6]  = '{16'h0803, 16'h6802, 6};
    vecs[7]  = '{16'h0802, 16'h6801, 6};
    vecs[8]  = '{16'h0003, 16'h4200, 16};
    vecs[9]  = '{16'h0400, 16'h6400, 7};
    vecs[10] = '{16'hFFFE, 16'hC000, 16};
    vecs[11] = '{16'h0064, 16'h5640, 11};
    vecs[12] = '{16'hFC18, 16'hE3D0, 8};
    vecs[13] = '{16'h0FFF, 16'h6C00, 6};
    vecs[14] = '{16'h1001, 16'h6C00, 5};
    vecs[15] = '{16'h1003, 16'h6C01, 5};
    vecs[16] = '{16'h0000, 16'h0000, 2};
    vecs[17] = '{16'hFFFF, 16'hBC00, 17};

    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.int_in = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_halt", {31'd0, bus.halt}, 32'd0);
    check("reset_flt", {16'd0, bus.flt_out}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      convert(vecs[i].din, res, lat);
      check($sformatf("vec%0d_flt_%h", i, vecs[i].din), {16'd0, res}, {16'd0, vecs[i].flt});
      check($sformatf("vec%0d_lat_%h", i, vecs[i].din), lat, vecs[i].lat);
    end

    // Reset mid-conversion discards the result and returns to IDLE.
    convert(16'h7FFF, res, lat);
    bus.int_in = 16'h0001;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midreset_halt", {31'd0, bus.halt}, 32'd0);
    check("midreset_flt", {16'd0, bus.flt_out}, 32'd0);
    halt_ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.halt || bus.flt_out !== 16'h0000) halt_ok = 1'b0;
    end
    check("midreset_stays_idle", {31'd0, halt_ok}, 32'd1);
    convert(16'h0003, res, lat);
    check("restart_flt", {16'd0, res}, 32'h4200);
    check("restart_lat", lat, 16);

    // Start pulsed while normalizing is ignored.
    bus.int_in = 16'h0001;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.int_in = 16'h7FFF;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    wait_done(5, 16'h4200, res, lat);
    check("norm_start_flt", {16'd0, res}, 32'h3C00);
    check("norm_start_lat", lat, 17);

    for (int k = 0; k < 1000; k++) begin
      logic [15:0] din;
      din = 16'($urandom);
      model(din, exp_f, exp_lat);
      convert(din, res, lat);
      check($sformatf("rand_flt_%h", din), {16'd0, res}, {16'd0, exp_f});
      check($sformatf("rand_lat_%h", din), lat, exp_lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
